// File: rtl/muldiv_seq_pkg.sv
// ============================================================================
//  Module      : muldiv_seq_pkg
//  Description : Shared RV32M operation codes, result constant and opcode
//                classification helpers for the multi-cycle mul/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package muldiv_seq_pkg;

    // RV32M operation codes carried on the 5-bit control bus
    localparam logic [4:0] OPMUL    = 5'h10;
    localparam logic [4:0] OPMULH   = 5'h11;
    localparam logic [4:0] OPMULHU  = 5'h12;
    localparam logic [4:0] OPMULHSU = 5'h13;
    localparam logic [4:0] OPDIV    = 5'h14;
    localparam logic [4:0] OPDIVU   = 5'h15;
    localparam logic [4:0] OPREM    = 5'h16;
    localparam logic [4:0] OPREMU   = 5'h17;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == OPMUL) || (op == OPMULH) || (op == OPMULHU) || (op == OPMULHSU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div_core.sv
// ============================================================================
//  Module      : muldiv_div_core
//  Description : Restoring divider datapath, one quotient bit per i_step.
//                Operates on unsigned magnitudes; sign handling is external.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_load          - capture dividend/divisor, clear remainder
//                i_step          - perform one shift/compare/subtract
//                i_dividend/i_divisor - operand magnitudes
//                o_quotient/o_remainder - results after 32 steps
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;

    // Partial remainder shifted left with the next dividend bit; 33 bits wide
    // because the shifted remainder can exceed 32 bits before subtraction.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_diff[32];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= 32'h0;
            r_quo <= 32'h0;
            r_div <= 32'h0;
        end else if (i_load) begin
            r_rem <= 32'h0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_quo <= {r_quo[30:0], w_ge};
            r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
//  Module      : muldiv_seq
//  Description : Multi-cycle RV32M sequencer. Pipelined multiply
//                (MUL_STAGES stages), restoring 32-cycle divide plus a
//                sign-fix cycle, single-cycle divide special cases.
//  Ports       : iCLK, iRST (sync, active-high)
//                iValid/oReady - request handshake, accept on both high
//                iControl, iA, iB - opcode and operands, latched at accept
//                iFlush        - abort in-flight operation
//                oValid/oResult - one-cycle result pulse, result held
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iValid,
    output logic        oReady,
    input  logic [4:0]  iControl,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iFlush,
    output logic        oValid,
    output logic [31:0] oResult
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] c_MUL_LAST = 6'(MUL_STAGES - 1);
    localparam logic [5:0] c_DIV_FIX  = 6'd32;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_op;
    logic        r_negq;
    logic        r_negr;
    logic        r_valid;
    logic [31:0] r_result;

    // ---------------- accept-time decode (on live inputs) ----------------
    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed_div;
    logic        w_is_rem;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    assign oReady       = (r_state == S_IDLE) && !iRST;
    assign w_accept     = iValid && oReady && !iFlush;
    assign w_is_mul     = is_mul_op(iControl);
    assign w_is_div     = is_div_op(iControl);
    assign w_signed_div = (iControl == OPDIV) || (iControl == OPREM);
    assign w_is_rem     = (iControl == OPREM) || (iControl == OPREMU);
    assign w_special    = w_is_div && ((iB == 32'h0) ||
                          (w_signed_div && iA == 32'h8000_0000 && iB == 32'hFFFF_FFFF));
    // Divide by zero: all-ones quotient, dividend as remainder.
    // Signed overflow: quotient is the dividend, remainder zero.
    assign w_special_res = (iB == 32'h0) ? (w_is_rem ? iA : 32'hFFFF_FFFF)
                                         : (w_is_rem ? ZERO : 32'h8000_0000);
    assign w_mag_a = (w_signed_div && iA[31]) ? (~iA + 32'd1) : iA;
    assign w_mag_b = (w_signed_div && iB[31]) ? (~iB + 32'd1) : iB;

    // ---------------- divider datapath ----------------
    logic        w_div_load;
    logic        w_div_step;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_div_res;
    logic        w_op_rem;

    assign w_div_load = w_accept && w_is_div && !w_special;
    assign w_div_step = (r_state == S_DIV) && (r_cnt != c_DIV_FIX) && !iFlush;
    assign w_op_rem   = (r_op == OPREM) || (r_op == OPREMU);
    assign w_div_res  = w_op_rem ? (r_negr ? (~w_rem + 32'd1) : w_rem)
                                 : (r_negq ? (~w_quo + 32'd1) : w_quo);

    muldiv_div_core u_div_core (
        .clk         (iCLK),
        .rst         (iRST),
        .i_load      (w_div_load),
        .i_step      (w_div_step),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // ---------------- product pipeline ----------------
    // Operands are sign- or zero-extended to 64 bits; the low 64 bits of the
    // unsigned product are then the correct two's-complement product.
    logic        w_a_sx;
    logic        w_b_sx;
    logic [63:0] w_ea;
    logic [63:0] w_eb;
    logic [63:0] w_pstage [MUL_STAGES];
    logic [63:0] w_prod_final;
    logic [31:0] w_mul_res;

    assign w_a_sx = ((r_op == OPMUL) || (r_op == OPMULH) || (r_op == OPMULHSU)) && r_a[31];
    assign w_b_sx = ((r_op == OPMUL) || (r_op == OPMULH)) && r_b[31];
    assign w_ea   = {{32{w_a_sx}}, r_a};
    assign w_eb   = {{32{w_b_sx}}, r_b};
    assign w_pstage[0] = w_ea * w_eb;

    // The result register is the last stage, so MUL_STAGES-1 extra registers.
    generate
        for (genvar s = 1; s < MUL_STAGES; s++) begin : g_pipe
            logic [63:0] r_p;
            always_ff @(posedge iCLK) begin
                r_p <= w_pstage[s-1];
            end
            assign w_pstage[s] = r_p;
        end
    endgenerate

    assign w_prod_final = w_pstage[MUL_STAGES-1];
    assign w_mul_res    = (r_op == OPMUL) ? w_prod_final[31:0] : w_prod_final[63:32];

    // ---------------- control FSM ----------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_op     <= 5'h0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= ZERO;
        end else begin
            r_valid <= 1'b0;
            if (iFlush) begin
                r_state <= S_IDLE;
                r_cnt   <= 6'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_a    <= iA;
                            r_b    <= iB;
                            r_op   <= iControl;
                            r_negq <= w_signed_div && (iA[31] ^ iB[31]);
                            r_negr <= w_signed_div && iA[31];
                            r_cnt  <= 6'd0;
                            if (w_is_mul) begin
                                r_state <= S_MUL;
                            end else if (w_is_div && !w_special) begin
                                r_state <= S_DIV;
                            end else begin
                                r_state  <= S_DONE;
                                r_valid  <= 1'b1;
                                r_result <= w_is_div ? w_special_res : ZERO;
                            end
                        end
                    end
                    S_MUL: begin
                        if (r_cnt == c_MUL_LAST) begin
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_mul_res;
                            r_cnt    <= 6'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    S_DIV: begin
                        // Count 32 is the sign-fix cycle after the last step.
                        if (r_cnt == c_DIV_FIX) begin
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_div_res;
                            r_cnt    <= 6'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign oValid  = r_valid;
    assign oResult = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Self-checking bench for muldiv_seq: directed vectors,
//                flush/reset aborts and a back-to-back random stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int MUL_STAGES = 2;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iValid;
    logic        iFlush;
    logic [4:0]  iControl;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oReady;
    logic        oValid;
    logic [31:0] oResult;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.MUL_STAGES(MUL_STAGES)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iValid   (iValid),
        .oReady   (oReady),
        .iControl (iControl),
        .iA       (iA),
        .iB       (iB),
        .iFlush   (iFlush),
        .oValid   (oValid),
        .oResult  (oResult)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        int          ia;
        int          ib;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'h0;
        model = 32'h0;
        case (op)
            OPMUL:    begin p = 64'(sa * sb); model = p[31:0];  end
            OPMULH:   begin p = 64'(sa * sb); model = p[63:32]; end
            OPMULHU:  begin p = 64'(ua * ub); model = p[63:32]; end
            OPMULHSU: begin p = 64'(sa * ub); model = p[63:32]; end
            OPDIV:    model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            OPDIVU:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OPREM:    model = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            OPREMU:   model = (b == 0) ? a : a % b;
            default:  model = 32'h0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (is_mul_op(op)) return MUL_STAGES + 1;
        if (is_div_op(op)) begin
            if (b == 0) return 1;
            if ((op == OPDIV || op == OPREM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        return 1;
    endfunction

    // Called at a negedge. Issues one op, scrambles inputs after accept,
    // then checks result, latency, single-cycle pulse and result hold.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat_exp, input string tag);
        int n;
        int lat;
        bit got;
        n = 0;
        while (!oReady && n < 100) begin
            @(negedge iCLK);
            n++;
        end
        check({tag, " ready"}, 32'(oReady), 32'd1);
        iValid = 1'b1; iControl = op; iA = a; iB = b;
        @(posedge iCLK);
        #1;
        iValid = 1'b0; iControl = 5'h03; iA = ~a; iB = a ^ b ^ 32'h5A5A_5A5A;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge iCLK);
            lat++;
            if (oValid) got = 1'b1;
        end
        check({tag, " result"}, oResult, exp);
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        @(negedge iCLK);
        check({tag, " pulse width"}, 32'(oValid), 32'd0);
        check({tag, " hold"}, oResult, exp);
    endtask

    logic [4:0] ops [9];

    initial begin
        int          pulses;
        int          accepted;
        int          cyc;
        int          lat;
        int          explat;
        bit          pending;
        logic [31:0] expr;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        ops = '{OPMUL, OPMULH, OPMULHU, OPMULHSU, OPDIV, OPDIVU, OPREM, OPREMU, 5'h02};

        iRST = 1'b1; iValid = 1'b0; iFlush = 1'b0; iControl = 5'h0; iA = 32'h0; iB = 32'h0;
        repeat (3) @(negedge iCLK);
        check("reset ready", 32'(oReady), 32'd0);
        check("reset valid", 32'(oValid), 32'd0);
        check("reset result", oResult, 32'h0);
        iRST = 1'b0;
        @(negedge iCLK);
        check("ready after reset", 32'(oReady), 32'd1);

        // Directed vectors with hand-computed results
        do_op(OPMUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 3,  "mul -3*7");
        do_op(OPMULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3,  "mulh");
        do_op(OPMULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3,  "mulhu");
        do_op(OPMULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,  "mulhsu");
        do_op(OPDIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div -7/2");
        do_op(OPREM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem -7/2");
        do_op(OPDIVU,   32'd100,       32'd7,         32'd14,        34, "divu 100/7");
        do_op(OPREMU,   32'd100,       32'd7,         32'd2,         34, "remu 100/7");
        do_op(OPDIV,    32'd1234,      32'd0,         32'hFFFF_FFFF, 1,  "div x/0");
        do_op(OPREMU,   32'd5,         32'd0,         32'd5,         1,  "remu 5/0");
        do_op(OPDIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div ovf");
        do_op(OPREM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  "rem ovf");
        do_op(5'h02,    32'd9,         32'd9,         ZERO,          1,  "non-M");
        do_op(OPDIVU,   32'd100,       32'd7,         32'd14,        34, "divu before flush");

        // Flush at iteration 10 of a divide
        iValid = 1'b1; iControl = OPDIV; iA = 32'd1000; iB = 32'd3;
        @(posedge iCLK);
        #1;
        iValid = 1'b0;
        repeat (11) @(negedge iCLK);
        iFlush = 1'b1;
        @(negedge iCLK);
        iFlush = 1'b0;
        check("flush ready", 32'(oReady), 32'd1);
        check("flush valid", 32'(oValid), 32'd0);
        check("flush result", oResult, 32'd14);
        pulses = 0;
        repeat (40) begin
            @(negedge iCLK);
            if (oValid) pulses++;
        end
        check("flush no pulse", 32'(pulses), 32'd0);

        // Flush coincident with a request in IDLE blocks the accept
        iValid = 1'b1; iFlush = 1'b1; iControl = OPMUL; iA = 32'd2; iB = 32'd3;
        @(negedge iCLK);
        iValid = 1'b0; iFlush = 1'b0;
        check("flush blocks accept", 32'(oReady), 32'd1);
        pulses = 0;
        repeat (5) begin
            @(negedge iCLK);
            if (oValid) pulses++;
        end
        check("flush blocks pulse", 32'(pulses), 32'd0);
        check("flush blocks result", oResult, 32'd14);

        // Reset in the middle of a multiply (oResult is zero beforehand)
        do_op(5'h02, 32'd1, 32'd1, ZERO, 1, "non-M before reset");
        iValid = 1'b1; iControl = OPMUL; iA = 32'd6; iB = 32'd7;
        @(posedge iCLK);
        #1;
        iValid = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        check("reset mid-mul ready low", 32'(oReady), 32'd0);
        iRST = 1'b0;
        @(negedge iCLK);
        check("reset mid-mul ready", 32'(oReady), 32'd1);
        check("reset mid-mul valid", 32'(oValid), 32'd0);
        check("reset mid-mul result", oResult, 32'h0);
        pulses = 0;
        repeat (6) begin
            @(negedge iCLK);
            if (oValid) pulses++;
        end
        check("reset mid-mul no pulse", 32'(pulses), 32'd0);

        // Back-to-back stream with iValid held high
        accepted = 0; pulses = 0; cyc = 0; pending = 1'b0; lat = 0; explat = 0; expr = 32'h0;
        iValid = 1'b1;
        while (!(accepted == 1000 && !pending) && cyc < 60000) begin
            if (oValid) begin
                check("stream pulse expected", 32'(pending), 32'd1);
                check("stream result", oResult, expr);
                check("stream latency", 32'(lat), 32'(explat));
                pending = 1'b0;
                pulses++;
            end
            if (oReady) begin
                check("stream ready while busy", 32'(pending), 32'd0);
                if (accepted < 1000) begin
                    op = ops[$urandom_range(0, 8)];
                    a  = $urandom;
                    b  = $urandom;
                    if ($urandom_range(0, 7) == 0) b = 32'h0;
                    if ($urandom_range(0, 15) == 0) begin
                        a = 32'h8000_0000;
                        b = 32'hFFFF_FFFF;
                    end
                    if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
                    iControl = op; iA = a; iB = b;
                    expr    = model(op, a, b);
                    explat  = exp_lat(op, a, b);
                    pending = 1'b1;
                    lat     = 0;
                    accepted++;
                end else begin
                    iValid = 1'b0;
                end
            end else begin
                iA = $urandom;
                iB = $urandom;
                iControl = ops[$urandom_range(0, 8)];
            end
            @(negedge iCLK);
            cyc++;
            if (pending) lat++;
        end
        iValid = 1'b0;
        check("stream pulse count", 32'(pulses), 32'd1000);
        check("stream drained", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
